rv32_trap_ctrl: RTL

// Sequences machine-mode trap entry and MRET return. It owns the single CSR-bank write port,

---
 rtl/rv32_trap_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rv32_trap_ctrl.sv
// rtl/rv32_trap_ctrl.sv - machine-mode trap entry / MRET sequencer and CSR write-port owner
//
// Purpose:
//   Accepts a committed exception, an enabled external interrupt or an MRET.
//   Priority is exception, then interrupt, then MRET. It stalls the pipeline
//   while it writes mepc/mcause/mstatus (trap) or mstatus (MRET) through the
//   single CSR-bank write port, then pulses a PC redirect.
//   When idle, the write port is a combinational pass-through of the pipeline's
//   CSR write request.
//
// Configuration:
//   RV32_TRAP_VECTORED_EN - when defined, interrupts taken with
//   mtvec[1:0] == 2'b01 redirect to base + 4*IRQ_CAUSE. Exceptions always go to
//   base. When undefined, mtvec[1:0] is ignored.
//
// Ports:
//   clk, reset                      core clock, synchronous active-high reset
//   mstatus_mie, mstatus_mpie       current mstatus.MIE / MPIE from the CSR bank
//   mtvec, mepc                     current mtvec / mepc from the CSR bank
//   exc_valid, exc_cause, exc_pc    synchronous exception at commit
//   irq_ext, irq_pc                 level external interrupt, PC saved for it
//   mret_valid                      MRET at commit
//   pipe_csr_write/id/value         pipeline CSR write request
//   csr_write/id/value              CSR bank write port
//   trap_stall                      freeze fetch/decode/commit
//   redirect_valid, redirect_pc     one-cycle PC redirect

module rv32_trap_ctrl #(
  parameter int IRQ_CAUSE   = 11,
  parameter int EXC_CAUSE_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mstatus_mie,
  input  logic                   mstatus_mpie,
  input  logic [31:0]            mtvec,
  input  logic [31:0]            mepc,
  input  logic                   exc_valid,
  input  logic [EXC_CAUSE_W-1:0] exc_cause,
  input  logic [31:0]            exc_pc,
  input  logic                   irq_ext,
  input  logic [31:0]            irq_pc,
  input  logic                   mret_valid,
  input  logic                   pipe_csr_write,
  input  logic [11:0]            pipe_csr_id,
  input  logic [31:0]            pipe_csr_value,
  output logic                   csr_write,
  output logic [11:0]            csr_id,
  output logic [31:0]            csr_value,
  output logic                   trap_stall,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc
);

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_STATUS,
    T_REDIR,
    M_STATUS,
    M_REDIR
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [31:0] IRQ_MCAUSE  = 32'h8000_0000 | 32'(IRQ_CAUSE);

  state_t      state;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic        old_mie_q;

  logic        idle;
  logic        take_exc;
  logic        take_irq;
  logic        take_mret;
  logic        accept;
  logic [31:0] trap_target;

  // Reset masks acceptance so that nothing starts in the reset cycle.
  assign idle      = (state == IDLE) && !reset;
  assign take_exc  = idle && exc_valid;
  assign take_irq  = idle && !exc_valid && irq_ext && mstatus_mie;
  assign take_mret = idle && !exc_valid && !(irq_ext && mstatus_mie) && mret_valid;
  assign accept    = take_exc || take_irq || take_mret;

`ifdef RV32_TRAP_VECTORED_EN
  localparam logic [31:0] IRQ_VEC_OFS = 32'(IRQ_CAUSE) << 2;

  // cause_q[31] marks an interrupt; only interrupts use the vector table.
  assign trap_target = {mtvec[31:2], 2'b00} +
                       ((cause_q[31] && (mtvec[1:0] == 2'b01)) ? IRQ_VEC_OFS : 32'd0);
`else
  logic unused_mtvec_mode;

  assign trap_target       = {mtvec[31:2], 2'b00};
  assign unused_mtvec_mode = ^mtvec[1:0];
`endif

  logic unused_mepc_lo;
  assign unused_mepc_lo = ^mepc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      old_mie_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_exc) begin
            epc_q     <= exc_pc;
            cause_q   <= 32'(exc_cause);
            old_mie_q <= mstatus_mie;
            state     <= T_EPC;
          end else if (take_irq) begin
            epc_q     <= irq_pc;
            cause_q   <= IRQ_MCAUSE;
            old_mie_q <= mstatus_mie;
            state     <= T_EPC;
          end else if (take_mret) begin
            old_mie_q <= mstatus_mie;
            state     <= M_STATUS;
          end
        end
        T_EPC:    state <= T_CAUSE;
        T_CAUSE:  state <= T_STATUS;
        T_STATUS: state <= T_REDIR;
        T_REDIR:  state <= IDLE;
        M_STATUS: state <= M_REDIR;
        M_REDIR:  state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the current state. mtvec/mepc/MPIE are read live
  // so the redirect sees the CSR values written earlier in the same sequence.
  always_comb begin
    csr_write      = 1'b0;
    csr_id         = '0;
    csr_value      = '0;
    trap_stall     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!reset) begin
      trap_stall = (state != IDLE) || accept;
      case (state)
        IDLE: begin
          // The committing instruction is older than any event accepted now,
          // so its CSR write still goes through in the accept cycle.
          csr_write = pipe_csr_write;
          csr_id    = pipe_csr_id;
          csr_value = pipe_csr_value;
        end
        T_EPC: begin
          csr_write = 1'b1;
          csr_id    = CSR_MEPC;
          csr_value = epc_q;
        end
        T_CAUSE: begin
          csr_write = 1'b1;
          csr_id    = CSR_MCAUSE;
          csr_value = cause_q;
        end
        T_STATUS: begin
          // MIE cleared, MPIE gets the pre-trap MIE.
          csr_write = 1'b1;
          csr_id    = CSR_MSTATUS;
          csr_value = {24'b0, old_mie_q, 7'b0};
        end
        T_REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = trap_target;
        end
        M_STATUS: begin
          // MIE restored from MPIE, MPIE set.
          csr_write = 1'b1;
          csr_id    = CSR_MSTATUS;
          csr_value = {24'b0, 1'b1, 3'b0, mstatus_mpie, 3'b0};
        end
        M_REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = {mepc[31:2], 2'b00};
        end
        default: ;
      endcase
    end
  end

endmodule
